// File: rtl/compare_seq_n_if.sv
// Request/result bundle for the digit-serial magnitude comparator.
// master: issues requests and observes results; slave: the comparator.
interface compare_seq_n_if #(
  parameter int N = 8,
  parameter int K = 2
);
  logic                          start_i;
  logic                          sign_i;
  logic [N-1:0]                  data0_i;
  logic [N-1:0]                  data1_i;
  logic                          ready_o;
  logic                          valid_o;
  logic [1:0]                    sig_o;
  logic [$clog2(N/K+1)-1:0]      cycles_o;

  modport master (
    output start_i, sign_i, data0_i, data1_i,
    input  ready_o, valid_o, sig_o, cycles_o
  );

  modport slave (
    input  start_i, sign_i, data0_i, data1_i,
    output ready_o, valid_o, sig_o, cycles_o
  );
endinterface

// File: rtl/compare_seq_n.sv
// Digit-serial magnitude comparator: compares two N-bit operands K bits per
// cycle, most significant digit first, signed or unsigned per request.
// sig_o: 00 A==B, 01 A<B, 10 A>B.
// Optional feature macro: COMPARE_SEQ_EARLY_EXIT_EN
//   defined   -> stop at the first differing digit (data-dependent latency)
//   undefined -> constant time, all N/K digits always evaluated
module compare_seq_n #(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  compare_seq_n_if.slave  bus
);
  localparam int D  = N / K;
  localparam int CW = $clog2(D + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so every digit can then be compared unsigned.
  localparam logic [N-1:0] MSB_MASK = {1'b1, {(N-1){1'b0}}};

  if (N % K != 0) begin : g_param_err
    $error("compare_seq_n: N must be a multiple of K");
  end

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [CW-1:0] j_q, j_d;
  logic [1:0]    sig_q, sig_d;
  logic [CW-1:0] cycles_q, cycles_d;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
  logic          decided_q, decided_d;
  logic [1:0]    dsig_q, dsig_d;
`endif

  logic [K-1:0]  a_dig [D];
  logic [K-1:0]  b_dig [D];
  logic [K-1:0]  cur_a, cur_b;
  logic [1:0]    dig_sig;
  logic          last_dig;

  // Split latched operands into digits; digit 0 is the most significant.
  for (genvar gi = 0; gi < D; gi++) begin : g_digits
    assign a_dig[gi] = a_q[N-1-gi*K -: K];
    assign b_dig[gi] = b_q[N-1-gi*K -: K];
  end

  // Select the digit pair under evaluation and compare it.
  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < D; i++) begin
      if (j_q == CW'(i)) begin
        cur_a = a_dig[i];
        cur_b = b_dig[i];
      end
    end
    if (cur_a > cur_b)      dig_sig = 2'b10;
    else if (cur_a < cur_b) dig_sig = 2'b01;
    else                    dig_sig = 2'b00;
    last_dig = (j_q == CW'(D - 1));
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    j_d      = j_q;
    sig_d    = sig_q;
    cycles_d = cycles_q;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
    decided_d = decided_q;
    dsig_d    = dsig_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_RUN;
          a_d     = bus.data0_i ^ (bus.sign_i ? MSB_MASK : '0);
          b_d     = bus.data1_i ^ (bus.sign_i ? MSB_MASK : '0);
          j_d     = '0;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
          decided_d = 1'b0;
          dsig_d    = 2'b00;
`endif
        end
      end
      S_RUN: begin
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
        if (dig_sig != 2'b00 || last_dig) begin
          state_d  = S_DONE;
          sig_d    = dig_sig;
          cycles_d = j_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
`else
        // The first differing digit is sticky; later digits are still
        // walked so the latency never depends on the data.
        if (!decided_q && dig_sig != 2'b00) begin
          decided_d = 1'b1;
          dsig_d    = dig_sig;
        end
        if (last_dig) begin
          state_d  = S_DONE;
          sig_d    = decided_q ? dsig_q : dig_sig;
          cycles_d = CW'(D);
        end else begin
          j_d = j_q + 1'b1;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      j_q      <= '0;
      sig_q    <= 2'b00;
      cycles_q <= '0;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
      decided_q <= 1'b0;
      dsig_q    <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      j_q      <= j_d;
      sig_q    <= sig_d;
      cycles_q <= cycles_d;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
      decided_q <= decided_d;
      dsig_q    <= dsig_d;
`endif
    end
  end

  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.valid_o  = (state_q == S_DONE);
  assign bus.sig_o    = sig_q;
  assign bus.cycles_o = cycles_q;
endmodule

// File: tb/tb_compare_seq_n.sv
// Randomised bench for compare_seq_n with a behavioural reference model.
module tb_compare_seq_n;
  localparam int N = 8;
  localparam int K = 2;
  localparam int D = N / K;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  compare_seq_n_if #(.N(N), .K(K)) bus ();
  compare_seq_n #(.N(N), .K(K)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    logic [1:0]   sig;
    int           cyc;
    bit           has_lit;
    logic [1:0]   lit_sig;
    int           lit_cyc;
  } txn_t;

  txn_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         remaining = 0;
  int         accepts = 0;
  logic [1:0] last_sig = 2'b00;
  int         last_cyc = 0;
  bit         lit_pending = 1'b0;
  logic [1:0] lit_sig_next = 2'b00;
  int         lit_cyc_next = 0;

  // Magnitude order from plain integer comparison.
  function automatic logic [1:0] ref_sig(logic [N-1:0] a, logic [N-1:0] b, logic s);
    if (s) begin
      if ($signed(a) > $signed(b)) return 2'b10;
      if ($signed(a) < $signed(b)) return 2'b01;
      return 2'b00;
    end
    if (a > b) return 2'b10;
    if (a < b) return 2'b01;
    return 2'b00;
  endfunction

  // Digits inspected: position of first differing digit when exiting early, else all.
  function automatic int ref_cyc(logic [N-1:0] a, logic [N-1:0] b);
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
    for (int i = 0; i < D; i++) begin
      if (((a >> (N - K*(i+1))) & ((1 << K) - 1)) != ((b >> (N - K*(i+1))) & ((1 << K) - 1)))
        return i + 1;
    end
`endif
    return D;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model update on each rising edge, comparison on each falling edge.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (remaining > 0) remaining--;
        else if (bus.start_i) begin
          t.a = bus.data0_i;
          t.b = bus.data1_i;
          t.s = bus.sign_i;
          t.sig = ref_sig(t.a, t.b, t.s);
          t.cyc = ref_cyc(t.a, t.b);
          t.has_lit = lit_pending;
          t.lit_sig = lit_sig_next;
          t.lit_cyc = lit_cyc_next;
          lit_pending = 1'b0;
          exp_q.push_back(t);
          remaining = t.cyc + 1;
          accepts++;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        remaining = 0;
        last_sig = 2'b00;
        last_cyc = 0;
      end
      check("ready", {31'b0, bus.ready_o}, {31'b0, remaining == 0});
      check("valid", {31'b0, bus.valid_o}, {31'b0, remaining == 1});
      if (remaining == 1 && exp_q.size() > 0) begin
        t = exp_q.pop_front();
        last_sig = t.sig;
        last_cyc = t.cyc;
        if (t.has_lit) begin
          check("model_sig", {30'b0, t.sig}, {30'b0, t.lit_sig});
          check("model_cyc", t.cyc, t.lit_cyc);
          check("lit_sig", {30'b0, bus.sig_o}, {30'b0, t.lit_sig});
          check("lit_cyc", {29'b0, bus.cycles_o}, t.lit_cyc);
        end
        $display("[TB] op a=%02h b=%02h signed=%0d -> sig=%b cycles=%0d (exp %b/%0d)",
                 t.a, t.b, t.s, bus.sig_o, bus.cycles_o, t.sig, t.cyc);
      end
      check("sig", {30'b0, bus.sig_o}, {30'b0, last_sig});
      check("cycles", {29'b0, bus.cycles_o}, last_cyc);
    end
  end

  task automatic wait_accept(int n0);
    int guard = 0;
    while (accepts == n0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (accepts == n0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout at %0t: got no accept, expected one", $time);
    end
  endtask

  task automatic issue(logic [N-1:0] a, logic [N-1:0] b, logic s,
                       bit lit, logic [1:0] lsig, int lcyc);
    int n0 = accepts;
    bus.start_i = 1'b1;
    bus.data0_i = a;
    bus.data1_i = b;
    bus.sign_i  = s;
    lit_pending  = lit;
    lit_sig_next = lsig;
    lit_cyc_next = lcyc;
    wait_accept(n0);
    bus.start_i = 1'b0;
  endtask

  // start_i held high with operands churning every cycle.
  task automatic held_start(int n_ops);
    int n0 = accepts;
    int guard = 0;
    bus.start_i = 1'b1;
    while (accepts < n0 + n_ops && guard < 200) begin
      bus.data0_i = N'($urandom);
      bus.data1_i = N'($urandom);
      bus.sign_i  = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (accepts < n0 + n_ops) begin
      tests++;
      fails++;
      $display("FAIL held_timeout at %0t: got %0d accepts, expected %0d", $time, accepts - n0, n_ops);
    end
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (remaining != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (remaining != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout at %0t: got busy, expected idle", $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, b;
    int sh;
    bus.start_i = 1'b0;
    bus.sign_i  = 1'b0;
    bus.data0_i = '0;
    bus.data1_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef COMPARE_SEQ_EARLY_EXIT_EN
    issue(8'hA5, 8'hA5, 1'b0, 1'b1, 2'b00, 4);
    issue(8'h80, 8'h7F, 1'b0, 1'b1, 2'b10, 1);
    issue(8'h80, 8'h7F, 1'b1, 1'b1, 2'b01, 1);
`else
    issue(8'hA5, 8'hA5, 1'b0, 1'b1, 2'b00, 4);
    issue(8'h80, 8'h7F, 1'b0, 1'b1, 2'b10, 4);
    issue(8'h80, 8'h7F, 1'b1, 1'b1, 2'b01, 4);
`endif
    issue(8'hFF, 8'hFE, 1'b1, 1'b1, 2'b10, 4);
    drain();

    // Reset two cycles into a run: no result may follow.
    issue(8'h33, 8'h33, 1'b0, 1'b0, 2'b00, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h01, 8'h02, 1'b0, 1'b1, 2'b01, 4);
    drain();

    held_start(5);
    drain();

    for (int i = 0; i < 300; i++) begin
      a = N'($urandom);
      sh = $urandom_range(0, N);
      if ($urandom_range(0, 3) == 0) b = N'($urandom);
      else b = a ^ (N'($urandom) & N'((1 << sh) - 1));
      issue(a, b, 1'($urandom), 1'b0, 2'b00, 0);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
